// File: rtl/aes_dec_pkg.sv
// Shared definitions for the iterative AES-128 decryption core.
//   - inverse S-box table (index = input byte)
//   - GF(2^8) helpers xtime / gf_mul, reduction polynomial 0x11B
//   - round count, FSM state enum, 128-bit state type (FIPS byte order)
package aes_dec_pkg;

  localparam int NUM_ROUNDS_AES128 = 10;

  // Bits [0:7] hold byte 0 = s(row0,col0); bytes run column-major.
  typedef logic [0:127] aes_state_t;

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} fsm_e;

  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant operand it folds to an XOR tree.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (unless skip_mix)
// Ports: state, round_key (FIPS order), skip_mix (final round), next_state.
module aes_inv_round
  import aes_dec_pkg::*;
(
  input  aes_state_t state,
  input  aes_state_t round_key,
  input  logic       skip_mix,
  output aes_state_t next_state
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [3:0][7:0] a;  // after ShiftRows/SubBytes/AddRoundKey, indexed by row
    logic [3:0][7:0] m;  // after InvMixColumns
    for (genvar r = 0; r < 4; r++) begin : g_row
      // Row r rotates right by r: output col c takes input col (c-r) mod 4.
      // SubBytes is bytewise, so it is applied at the source byte.
      localparam int SRC = r + 4 * ((c - r + 4) % 4);
      assign a[r] = inv_sbox(state[8*SRC +: 8]) ^ round_key[32*c + 8*r +: 8];
      assign m[r] = gf_mul(a[r],           8'h0e) ^ gf_mul(a[(r + 1) % 4], 8'h0b)
                  ^ gf_mul(a[(r + 2) % 4], 8'h0d) ^ gf_mul(a[(r + 3) % 4], 8'h09);
    end
    assign next_state[32*c +: 32] = skip_mix ? {a[0], a[1], a[2], a[3]}
                                             : {m[0], m[1], m[2], m[3]};
  end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryption core: one inverse round per clock, round keys
// fetched from an external store in order 10..0 via key_round/round_key.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     ciphertext handshake (ciphertext, FIPS byte order)
//   key_round/round_key   key-store index and same-cycle key data
//   out_valid/out_ready   plaintext handshake (plaintext, FIPS byte order)
//   busy                  high in LOAD and ROUND
//   abort                 only with AES_DEC_ABORT_EN defined: drop the
//                         current block and return to IDLE
module aes_decrypt_iter
  import aes_dec_pkg::*;
#(
  parameter int NUM_ROUNDS   = 10,
  parameter bit CLEAR_ON_POP = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] ciphertext,
  output logic [3:0]   key_round,
  input  logic [0:127] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] plaintext,
  output logic         busy
`ifdef AES_DEC_ABORT_EN
  ,
  input  logic         abort
`endif
);

  if (NUM_ROUNDS != NUM_ROUNDS_AES128) begin : g_bad_rounds
    $error("aes_decrypt_iter: only NUM_ROUNDS=10 is supported");
  end

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS_AES128);

  fsm_e       fsm;
  aes_state_t st;
  aes_state_t rnd_out;
  logic [3:0] rnd;

  aes_inv_round u_round (
    .state      (st),
    .round_key  (round_key),
    .skip_mix   (rnd == 4'd0),
    .next_state (rnd_out)
  );

  // Outside ROUND the index parks at 10 so the store can pre-present it.
  assign key_round = (fsm == ROUND) ? rnd : LAST_RND;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      st        <= '0;
      rnd       <= LAST_RND;
      plaintext <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end
`ifdef AES_DEC_ABORT_EN
    else if (abort && fsm != IDLE) begin
      fsm       <= IDLE;
      st        <= '0;
      rnd       <= LAST_RND;
      plaintext <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end
`endif
    else begin
      unique case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            st       <= ciphertext;
            rnd      <= LAST_RND;
            fsm      <= LOAD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end else begin
            in_ready <= 1'b1;
          end
        end
        LOAD: begin
          st  <= st ^ round_key;
          rnd <= LAST_RND - 4'd1;
          fsm <= ROUND;
        end
        ROUND: begin
          if (rnd == 4'd0) begin
            plaintext <= rnd_out;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            fsm       <= DONE;
          end else begin
            st  <= rnd_out;
            rnd <= rnd - 4'd1;
          end
        end
        DONE: begin
          // IDLE is always re-entered before the next block is taken.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (CLEAR_ON_POP) plaintext <= '0;
            rnd      <= LAST_RND;
            in_ready <= 1'b1;
            fsm      <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/aes_decrypt_iter.md
Name: aes_decrypt_iter

Overview:
- Iterative AES-128 decryption core. It is the inverse-direction counterpart of the existing encryption round/final-block datapath.
- Accepts one 128-bit ciphertext block per valid/ready handshake and returns the 128-bit plaintext after 11 processing cycles.
- Executes one inverse round per clock and fetches round keys from an external key store through an index/data pair, in descending order 10..0.
- Sits between the key-schedule store and the downstream plaintext consumer.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds. Only 10 (AES-128) is supported; any other value is a elaboration error.
- CLEAR_ON_POP, 1, when 1 the plaintext register is zeroed on the output handshake; when 0 it holds its value.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  ciphertext is offered.
- in_ready  output  1  core can accept a block.
- ciphertext  input  [0:127]  FIPS-197 byte order: bits [0:7] = byte 0 = s(row0,col0), column-major.
- key_round  output  [3:0]  index of the round key required this cycle.
- round_key  input  [0:127]  round key for key_round, combinationally valid in the same cycle, same byte order as ciphertext.
- out_valid  output  1  plaintext is available.
- out_ready  input  1  consumer accepts plaintext.
- plaintext  output  [0:127]  result, same byte order as ciphertext.
- busy  output  1  high in LOAD and ROUND states.

Behaviour:
- Reset values: in_ready=0, out_valid=0, plaintext=0, key_round=10, busy=0, FSM=IDLE, state register=0, round counter=10.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge E0, state<=ciphertext, rnd<=10, next state LOAD.
  - LOAD: key_round=10. At E1, state<=state^round_key, rnd<=9, next state ROUND.
  - ROUND: key_round=rnd.
    - For rnd 9..1 (edges E2..E10): state<=InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)),round_key)), rnd<=rnd-1.
    - For rnd=0 (edge E11): plaintext<=AddRoundKey(InvSubBytes(InvShiftRows(state)),round_key), out_valid<=1, next state DONE.
  - DONE: holds plaintext and out_valid until out_valid&&out_ready. On that edge: out_valid<=0, plaintext cleared if CLEAR_ON_POP, next state IDLE.
- Latency: out_valid rises 11 clock edges after the input handshake edge. Throughput is one block per 13 cycles minimum, with out_ready tied high.
- Arithmetic rules:
  - GF(2^8) multiplication uses reduction polynomial 0x11B.
  - InvMixColumns coefficients are {0e,0b,0d,09} per column.
  - InvShiftRows rotates row r right by r bytes.
  - Bytes are mapped to rows and columns as byte k -> row k%4, col k/4.
  - Any row-major internal layout is converted inside the block; ports are always FIPS order.
- in_ready is 0 outside IDLE. in_valid presented during LOAD/ROUND/DONE is ignored and the ciphertext is not sampled.
- No input bypass: a new block cannot be accepted on the same edge as the output handshake. IDLE is re-entered first.
- Counter wrap-around: rnd never decrements below 0. The ROUND→DONE transition is taken at rnd=0.
- key_round outside LOAD/ROUND is held at 10, so the key store can pre-present key 10.
- round_key may change every cycle. The core never samples it outside LOAD/ROUND.
- Reset asserted mid-operation: all registers return to their reset values immediately. No partial result is ever presented.
- out_valid remains high with stable plaintext while out_ready is low (no drop).

Optional Feature:
- Macro AES_DEC_ABORT_EN.
- When defined, an input port abort (1 bit) is added.
  - abort=1 in LOAD, ROUND or DONE forces IDLE at the next edge.
  - On that edge the state register and plaintext are zeroed, out_valid<=0 and rnd<=10.
  - abort has priority over every other transition, including the out_valid handshake.
  - abort in IDLE has no effect. abort and in_valid in IDLE on the same edge: the block is accepted.
- When not defined, the port is absent and the FSM has no abort path.

Decomposition:
- Package aes_dec_pkg holds:
  - the 256-entry inverse S-box constant;
  - the xtime and gf_mul functions;
  - NUM_ROUNDS_AES128=10;
  - the FSM state enum {IDLE, LOAD, ROUND, DONE};
  - a 128-bit state typedef.
- Sub-module aes_inv_round: purely combinational. Inputs are state, round_key and skip_mix; output is the next state. It performs InvShiftRows→InvSubBytes→AddRoundKey→(InvMixColumns unless skip_mix).
- The top level holds the FSM, counter, registers and handshakes.

Test Plan:
- FIPS-197 C.1: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a with a key store expanding key 000102030405060708090a0b0c0d0e0f → plaintext 00112233445566778899aabbccddeeff, and out_valid exactly 11 edges after acceptance. key_round sequence observed: 10,9,...,0.
- FIPS-197 B: ciphertext 3925841d02dc09fbdc118597196a0b32, key 2b7e151628aed2a6abf7158809cf4f3c → plaintext 3243f6a8885a308d313198a2e0370734. out_ready held low 5 cycles → plaintext stable and in_ready=0 throughout.
- Back-to-back: in_valid held high with two blocks and out_ready=1 → second block accepted only after IDLE is re-entered. Both plaintexts are correct. A ciphertext change during ROUND has no effect.
- Reset: drop rst_n at rnd=5 → all outputs reach reset values without a clock edge. After release, a C.1 run produces a correct result.
- CLEAR_ON_POP=1: after the output handshake, plaintext=0. With CLEAR_ON_POP=0, plaintext keeps its value.
- AES_DEC_ABORT_EN: assert abort at rnd=3 → next edge IDLE, in_ready=1, out_valid never asserts. The following C.1 block decrypts correctly.
